// File: rtl/msu_audio_ctrl.sv
// Audio DAC buffer sequencer: streams track bytes from the memory arbiter into the
// double-buffered sample RAM, refilling the half the DAC is not playing.
module msu_audio_ctrl #(
  parameter int HALF_BYTES = 1024,
  parameter int AW         = 24
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic          cmd_loop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] loop_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          dac_status,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_data,
  output logic          dac_we,
  output logic [10:0]   dac_pgm_address,
  output logic [7:0]    dac_pgm_data,
  output logic          dac_play,
  output logic          dac_reset,
  output logic          busy,
  output logic          track_end,
  output logic          underrun
);

  localparam int HBIT = $clog2(HALF_BYTES);
  localparam int CW   = HBIT + 2;
  localparam logic [CW-1:0] FULL_CNT  = CW'(2 * HALF_BYTES);
  localparam logic [CW-1:0] HALF_CNT  = CW'(HALF_BYTES);
  localparam logic [10:0]   HALF_BASE = 11'(HALF_BYTES);
  localparam logic [AW-1:0] SRC_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_PRIME, S_WAIT, S_FILL, S_DRAIN, S_ABORT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] src_q;
  logic [10:0]   wp_q;
  logic [CW-1:0] rem_q;
  logic          loop_q, shadow_q, end_half_q, pend_q, pend_h_q, rst_cnt_q;
  logic          mem_req_q, dac_we_q, dac_play_q, dac_reset_q, track_end_q, underrun_q;
  logic [AW-1:0] mem_addr_q;
  logic [10:0]   dac_addr_q;
  logic [7:0]    dac_data_q;

  logic          at_end_d, pad_d, fill_edge_d, pend_any_d, pend_tgt_d, drain_ev_d, drain_play_d;
  logic [AW-1:0] fetch_addr_d;

  assign at_end_d     = (src_q == end_addr);
  assign pad_d        = at_end_d & ~loop_q;
  assign fetch_addr_d = (at_end_d & loop_q) ? loop_addr : src_q;
  // A DAC edge during FILL is remembered so the late half is refilled straight after.
  assign fill_edge_d  = (state_q == S_FILL) && (dac_status != shadow_q);
  assign pend_any_d   = pend_q | fill_edge_d;
  assign pend_tgt_d   = fill_edge_d ? ~dac_status : pend_h_q;
  assign drain_ev_d   = pend_q | (dac_status != shadow_q);
  assign drain_play_d = pend_q ? ~pend_h_q : dac_status;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      wp_q        <= '0;
      rem_q       <= '0;
      loop_q      <= 1'b0;
      shadow_q    <= 1'b0;
      end_half_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_h_q    <= 1'b0;
      rst_cnt_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      dac_we_q    <= 1'b1;
      dac_addr_q  <= '0;
      dac_data_q  <= '0;
      dac_play_q  <= 1'b0;
      dac_reset_q <= 1'b0;
      track_end_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      dac_we_q    <= 1'b1;
      track_end_q <= 1'b0;
      if (cmd_stop && state_q != S_IDLE) begin
        dac_play_q  <= 1'b0;
        dac_reset_q <= 1'b0;
        if (mem_req_q && !mem_ack) begin
          state_q <= S_ABORT;
        end else begin
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_start) begin
              loop_q      <= cmd_loop;
              src_q       <= start_addr;
              underrun_q  <= 1'b0;
              dac_reset_q <= 1'b1;
              dac_play_q  <= 1'b0;
              rst_cnt_q   <= 1'b0;
              state_q     <= S_RST;
            end
          end
          S_RST: begin
            rst_cnt_q <= 1'b1;
            if (rst_cnt_q) begin
              dac_reset_q <= 1'b0;
              wp_q        <= '0;
              rem_q       <= FULL_CNT;
              shadow_q    <= 1'b0;
              pend_q      <= 1'b0;
              end_half_q  <= 1'b1;
              state_q     <= S_PRIME;
            end
          end
          S_PRIME, S_FILL: begin
            if (fill_edge_d) begin
              shadow_q   <= dac_status;
              underrun_q <= 1'b1;
              pend_q     <= 1'b1;
              pend_h_q   <= ~dac_status;
            end
            if (mem_req_q) begin
              if (mem_ack) begin
                mem_req_q  <= 1'b0;
                dac_we_q   <= 1'b0;
                dac_addr_q <= wp_q;
                dac_data_q <= mem_data;
                end_half_q <= wp_q[HBIT];
                wp_q       <= wp_q + 11'd1;
                rem_q      <= rem_q - CNT_ONE;
                src_q      <= src_q + SRC_ONE;
              end
            end else if (rem_q == '0) begin
              if (state_q == S_PRIME) dac_play_q <= 1'b1;
              if (pad_d) begin
                state_q <= S_DRAIN;
              end else if (pend_any_d) begin
                wp_q    <= pend_tgt_d ? HALF_BASE : 11'd0;
                rem_q   <= HALF_CNT;
                pend_q  <= 1'b0;
                state_q <= S_FILL;
              end else begin
                state_q <= S_WAIT;
              end
            end else if (pad_d) begin
              dac_we_q   <= 1'b0;
              dac_addr_q <= wp_q;
              dac_data_q <= 8'h00;
              wp_q       <= wp_q + 11'd1;
              rem_q      <= rem_q - CNT_ONE;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_addr_d;
              src_q      <= fetch_addr_d;
            end
          end
          S_WAIT: begin
            if (dac_status != shadow_q) begin
              shadow_q <= dac_status;
              wp_q     <= dac_status ? 11'd0 : HALF_BASE;
              rem_q    <= HALF_CNT;
              state_q  <= S_FILL;
            end
          end
          S_DRAIN: begin
            // Zero-fill of a free half reuses FILL; it returns here since the source is exhausted.
            if (drain_ev_d) begin
              shadow_q <= dac_status;
              pend_q   <= 1'b0;
              if (drain_play_d != end_half_q) begin
                dac_play_q  <= 1'b0;
                track_end_q <= 1'b1;
                state_q     <= S_IDLE;
              end else begin
                wp_q    <= drain_play_d ? 11'd0 : HALF_BASE;
                rem_q   <= HALF_CNT;
                state_q <= S_FILL;
              end
            end
          end
          S_ABORT: begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign dac_we          = dac_we_q;
  assign dac_pgm_address = dac_addr_q;
  assign dac_pgm_data    = dac_data_q;
  assign dac_play        = dac_play_q;
  assign dac_reset       = dac_reset_q;
  assign busy            = (state_q != S_IDLE);
  assign track_end       = track_end_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_msu_audio_ctrl.sv
// Bench for msu_audio_ctrl: a memory responder with programmable/random ack delay,
// a spec-level model of the byte stream feeding a write scoreboard, and directed scenarios.
module tb_msu_audio_ctrl;

  logic        clkin, reset, cmd_start, cmd_stop, cmd_loop;
  logic [23:0] start_addr, loop_addr, end_addr;
  logic        dac_status, mem_req, mem_ack;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;
  logic        dac_we, dac_play, dac_reset, busy, track_end, underrun;
  logic [10:0] dac_pgm_address;
  logic [7:0]  dac_pgm_data;

  msu_audio_ctrl #(.HALF_BYTES(1024), .AW(24)) dut (
    .clkin(clkin), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_loop(cmd_loop), .start_addr(start_addr), .loop_addr(loop_addr),
    .end_addr(end_addr), .dac_status(dac_status), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .dac_we(dac_we),
    .dac_pgm_address(dac_pgm_address), .dac_pgm_data(dac_pgm_data),
    .dac_play(dac_play), .dac_reset(dac_reset), .busy(busy),
    .track_end(track_end), .underrun(underrun)
  );

  int tests = 0;
  int fails = 0;
  int ack_dly = 1;
  bit ack_rand = 0;
  logic [18:0] exp_q[$];
  logic [23:0] addr_log[$];

  // Track model state: read pointer, end/loop rules, and where the last real byte went.
  logic [23:0] m_src, m_end, m_loopaddr;
  bit          m_loop, m_padded, m_end_half;

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] memf(input logic [23:0] a);
    logic [7:0] m;
    m = a[15:8] * 8'd37;
    return a[7:0] ^ m ^ 8'h5C;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_fill(input logic [10:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [10:0] a;
      a = base + 11'(i);
      if (m_src == m_end && m_loop) m_src = m_loopaddr;
      if (m_src == m_end) begin
        exp_q.push_back({a, 8'h00});
        m_padded = 1'b1;
      end else begin
        exp_q.push_back({a, memf(m_src)});
        m_end_half = a[10];
        m_src = m_src + 24'd1;
      end
    end
  endtask

  // Flip the playing half; the freed half is refilled unless the track is leaving its last half.
  task automatic toggle_status();
    bit old;
    old = dac_status;
    if (!(m_padded && old == m_end_half)) model_fill(old ? 11'd1024 : 11'd0, 1024);
    dac_status = ~old;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_dac_we"}, dac_we, 1);
    chk({tag, "_pgm_addr"}, dac_pgm_address, 0);
    chk({tag, "_pgm_data"}, dac_pgm_data, 0);
    chk({tag, "_play"}, dac_play, 0);
    chk({tag, "_dac_reset"}, dac_reset, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_track_end"}, track_end, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic wait_empty(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clkin); #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_all_written"}, ok, 1);
  endtask

  task automatic start_track(input logic [23:0] s, input logic [23:0] l,
                             input logic [23:0] e, input bit lp);
    logic [2:0] rst_seen;
    logic [3:0] req_seen;
    m_src = s; m_end = e; m_loopaddr = l; m_loop = lp;
    m_padded = 1'b0; m_end_half = 1'b1;
    model_fill(11'd0, 2048);
    start_addr = s; loop_addr = l; end_addr = e; cmd_loop = lp;
    @(posedge clkin); #1 cmd_start = 1'b1;
    @(posedge clkin); #1 cmd_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clkin);
      if (c <= 3) rst_seen[3-c] = dac_reset;
      req_seen[4-c] = mem_req;
      if (c == 1) chk("start_clears_underrun", underrun, 0);
    end
    chk("start_dac_reset_2cyc", rst_seen, 3'b110);
    chk("start_first_req_lat4", req_seen, 4'b0001);
  endtask

  // Memory responder: ack after a fixed or random number of cycles, data = memf(addr).
  initial begin
    int cnt, dly;
    bit in_req;
    mem_ack = 1'b0; mem_data = 8'h00; in_req = 1'b0; cnt = 0; dly = 0;
    forever begin
      @(posedge clkin); #1;
      if (reset) begin
        mem_ack = 1'b0; in_req = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; in_req = 1'b0;
      end else if (mem_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1; cnt = 0;
          dly = ack_rand ? int'($urandom_range(0, 3)) : ack_dly;
        end
        if (cnt >= dly) begin
          mem_ack = 1'b1;
          mem_data = memf(mem_addr);
          addr_log.push_back(mem_addr);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Write monitor: every DAC buffer write must match the head of the scoreboard.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clkin);
      if (dac_we === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {13'd0, dac_pgm_address, dac_pgm_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("buffer_write", {dac_pgm_address, dac_pgm_data}, e);
        end
      end
    end
  end

  initial begin
    logic [2:0] seq3;
    int ack_c, idle_c;
    reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_loop = 1'b0;
    start_addr = '0; loop_addr = '0; end_addr = '0; dac_status = 1'b0;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    check_reset_vals("por");
    @(posedge clkin); #1 reset = 1'b0;

    // Plain track: prime, then a normal refill of the lower half.
    start_track(24'h001000, 24'h000000, 24'h002000, 1'b0);
    wait_empty("prime_a", 8000);
    chk("prime_a_play", dac_play, 1);
    chk("prime_a_busy", busy, 1);
    @(posedge clkin); #1 toggle_status();
    for (int c = 0; c < 3; c++) begin
      @(negedge clkin);
      seq3[2-c] = mem_req;
    end
    chk("status_edge_req_lat2", seq3, 3'b001);
    wait_empty("fill_a", 4000);
    chk("fill_a_no_underrun", underrun, 0);
    chk("fill_a_req_idle", mem_req, 0);
    @(posedge clkin); #1 cmd_stop = 1'b1;
    @(posedge clkin); #1 cmd_stop = 1'b0;
    @(negedge clkin);
    chk("stop_wait_busy", busy, 0);
    chk("stop_wait_play", dac_play, 0);
    chk("stop_no_track_end", track_end, 0);

    // Short non-looping track: padding, drain, then track_end.
    @(posedge clkin); #1 dac_status = 1'b0;
    start_track(24'h001000, 24'h000000, 24'h001900, 1'b0);
    wait_empty("prime_b", 8000);
    @(posedge clkin); #1 toggle_status();
    wait_empty("fill_pad_b", 4000);
    chk("drain_busy", busy, 1);
    chk("drain_play", dac_play, 1);
    @(posedge clkin); #1 toggle_status();
    wait_empty("drain_zero_fill", 2000);
    chk("drain_zero_no_end", track_end, 0);
    @(posedge clkin); #1 toggle_status();
    for (int c = 0; c < 3; c++) begin
      @(negedge clkin);
      seq3[2-c] = track_end;
      if (c == 1) begin
        chk("end_play_off", dac_play, 0);
        chk("end_busy_off", busy, 0);
      end
    end
    chk("track_end_pulse", seq3, 3'b010);
    repeat (5) @(posedge clkin);
    chk("end_no_stray_writes", exp_q.size(), 0);

    // Looping track with random ack delays.
    @(posedge clkin); #1 dac_status = 1'b0;
    addr_log.delete();
    ack_rand = 1'b1;
    start_track(24'h001000, 24'h001100, 24'h001200, 1'b1);
    wait_empty("prime_loop", 12000);
    ack_rand = 1'b0;
    chk("loop_req_count", addr_log.size(), 2048);
    for (int i = 0; i < addr_log.size() - 1; i++) begin
      if (addr_log[i] == 24'h0011FF) begin
        chk("loop_wrap_addr", addr_log[i+1], 24'h001100);
        break;
      end
    end
    @(posedge clkin); #1 cmd_stop = 1'b1;
    @(posedge clkin); #1 cmd_stop = 1'b0;

    // Underrun: second status edge lands during a slow fill.
    @(posedge clkin); #1 dac_status = 1'b0;
    start_track(24'h001000, 24'h000000, 24'h004000, 1'b0);
    wait_empty("prime_u", 8000);
    ack_dly = 10;
    @(posedge clkin); #1 toggle_status();
    repeat ($urandom_range(60, 300)) @(posedge clkin);
    #1 toggle_status();
    @(negedge clkin); @(negedge clkin);
    chk("underrun_set", underrun, 1);
    ack_dly = 1;
    wait_empty("underrun_fills", 12000);
    chk("underrun_sticky", underrun, 1);
    chk("underrun_busy", busy, 1);

    // Stop with a request outstanding: abort waits for the ack and discards it.
    ack_dly = 5;
    @(posedge clkin); #1 toggle_status();
    for (int i = 0; i < 20; i++) begin
      @(posedge clkin); #1;
      if (mem_req) break;
    end
    chk("abort_req_pending", mem_req, 1);
    exp_q.delete();
    cmd_stop = 1'b1;
    @(posedge clkin); #1 cmd_stop = 1'b0;
    @(negedge clkin);
    chk("abort_play_off", dac_play, 0);
    chk("abort_busy", busy, 1);
    ack_c = -1; idle_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkin);
      if (mem_ack) ack_c = c;
      if (!busy) begin
        idle_c = c;
        break;
      end
    end
    chk("abort_idle_after_ack", idle_c, ack_c + 1);
    chk("abort_req_released", mem_req, 0);
    chk("underrun_kept_after_stop", underrun, 1);
    ack_dly = 1;

    // Restart clears underrun; then reset in the middle of a fill.
    @(posedge clkin); #1 dac_status = 1'b0;
    start_track(24'h002000, 24'h000000, 24'h008000, 1'b0);
    wait_empty("prime_r", 8000);
    @(posedge clkin); #1 toggle_status();
    repeat ($urandom_range(20, 200)) @(posedge clkin);
    #1 reset = 1'b1;
    @(posedge clkin); #1 exp_q.delete();
    @(negedge clkin);
    check_reset_vals("midrst");
    @(posedge clkin); #1 reset = 1'b0;
    repeat (4) @(negedge clkin);
    chk("post_reset_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
